ahb_lite_sram_slave: RTL and testbench
======================================

AHB_LITE_SRAM_SLAVE -- requirements
Module: ahb_lite_sram_slave

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, bus data width; legal values are 32 and 64.
REQ-002 SHALL have parameter DEPTH_WORDS, default 256, memory depth in DATA_WIDTH words; power of two, at least 2.
REQ-003 SHALL have parameter WAIT_STATES, default 0, data-phase wait cycles per valid transfer; range 0 to 15.
REQ-004 SHALL have one clock and asynchronous active-high reset: HCLK  in  1  bus clock, all logic on rising edge.
REQ-005 SHALL have port HRESET  in  1  asynchronous active-high reset.
REQ-006 SHALL have port HSEL  in  1  slave select.
REQ-007 SHALL have port HADDR  in  32  byte address.
REQ-008 SHALL have port HTRANS  in  2  transfer type: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
REQ-009 SHALL have port HWRITE  in  1  1=write, 0=read.
REQ-010 SHALL have port HSIZE  in  3  transfer size: 000=byte, 001=half, 010=word, 011=dword.
REQ-011 SHALL have port HWDATA  in  DATA_WIDTH  write data, data phase.
REQ-012 SHALL have port HREADY  in  1  bus-level ready, qualifies the address phase.
REQ-013 SHALL have port HREADYOUT  out  1  slave ready.
REQ-014 SHALL have port HRESP  out  2  00=OKAY, 01=ERROR.
REQ-015 SHALL have port HRDATA  out  DATA_WIDTH  read data.

Function
REQ-016 Address phase accepted on a rising edge with HSEL=1, HREADY=1, HTRANS[1]=1; SHALL capture HADDR, HWRITE, HSIZE.
REQ-017 IDLE/BUSY, HSEL=0 or HREADY=0 SHALL NOT start a transfer; next cycle HREADYOUT=1, HRESP=00.
REQ-018 Word index = HADDR >> log2(DATA_WIDTH/8); transfer SHALL be illegal if index >= DEPTH_WORDS, HSIZE > log2(DATA_WIDTH/8), or HADDR not aligned to 2^HSIZE.
REQ-019 FSM states SHALL be IDLE, WAIT, ERR1, ERR2.
REQ-020 Legal transfer, WAIT_STATES=0: from IDLE, next cycle HREADYOUT=1, HRESP=00; FSM stays IDLE.
REQ-021 Legal transfer, WAIT_STATES=N>0: go to WAIT, HREADYOUT=0 for exactly N cycles via down-counter, then one cycle HREADYOUT=1, HRESP=00, return to IDLE.
REQ-022 Illegal transfer: ERR1 (HREADYOUT=0, HRESP=01) for one cycle, then ERR2 (HREADYOUT=1, HRESP=01), then IDLE; ERROR SHALL override WAIT_STATES; no memory write.
REQ-023 Writes: HWDATA sampled on the edge where HREADYOUT=1 completes the data phase; only byte lanes selected by HSIZE and HADDR low bits (little-endian) SHALL be updated.
REQ-024 Reads: HRDATA SHALL hold the full addressed word while HREADYOUT=1 in the data phase; unaddressed lanes carry memory contents.
REQ-025 Read whose address phase overlaps the data phase of a write to the same word SHALL return the newly written bytes (write forwarding).
REQ-026 New address phase accepted in the same cycle a data phase completes (pipelined back-to-back) SHALL be supported without bubbles when WAIT_STATES=0.
REQ-027 HRDATA SHALL hold its last value outside read data phases.

Reset
REQ-028 While HRESET=1: HREADYOUT=1, HRESP=00, HRDATA=0, FSM=IDLE, wait counter=0, asynchronously.
REQ-029 Memory contents SHALL NOT be reset.
REQ-030 Reset asserted mid-WAIT or mid-ERR SHALL abort the transfer; pending write SHALL NOT be committed.

Verification
REQ-031 WAIT_STATES=0: write word 0xDEADBEEF to 0x10, then read 0x10 back-to-back -> read data phase HRDATA=0xDEADBEEF, HREADYOUT=1, HRESP=00, no stall cycles.
REQ-032 Byte write 0xAA to 0x13 over word 0x11223344 at 0x10 -> read 0x10 returns 0xAA223344.
REQ-033 WAIT_STATES=3: single read -> HREADYOUT low exactly 3 cycles, then high 1 cycle with valid HRDATA.
REQ-034 DEPTH_WORDS=256, DATA_WIDTH=32: write to 0x400, then halfword write to 0x01 -> each gives ERR1 then ERR2 (HRESP=01), memory unchanged.
REQ-035 HTRANS=BUSY with HSEL=1, then HSEL=0 with NONSEQ -> HREADYOUT=1, HRESP=00, no memory access.
REQ-036 WAIT_STATES=4: write 0x55 to 0x20, assert HRESET in 2nd wait cycle -> outputs go to reset values immediately; later read of 0x20 returns old contents.

Source files
------------

// File: rtl/ahb_lite_sram_slave.sv
// ahb_lite_sram_slave: AHB-Lite SRAM slave with byte-lane writes, write forwarding, wait states and error responses.
module ahb_lite_sram_slave #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic [1:0]            HRESP,
  output logic [DATA_WIDTH-1:0] HRDATA
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int AW = $clog2(NB);
  localparam int IW = $clog2(DEPTH_WORDS);
  typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];
  state_t                r_state, w_state_nxt;
  logic [3:0]            r_cnt, w_cnt_nxt;
  logic                  r_pend, r_write;
  logic [IW-1:0]         r_idx;
  logic [NB-1:0]         r_be, w_be;
  logic [DATA_WIDTH-1:0] r_rdata, w_rword;
  logic                  w_rdy, w_acc, w_ill, w_ok, w_wr, w_fwd;
  logic [IW-1:0]         w_idx;
  assign w_rdy = (r_state == IDLE) || (r_state == ERR2);
  assign w_acc = HSEL && HREADY && (HTRANS == 2'b10 || HTRANS == 2'b11) && w_rdy;
  assign w_ill = ((HADDR >> AW) >= 32'(DEPTH_WORDS)) || (HSIZE > 3'(AW)) ||
                 (|(HADDR[6:0] & ~(7'h7f << HSIZE)));
  assign w_ok  = w_acc && !w_ill;
  assign w_idx = HADDR[AW +: IW];
  // a write data phase completes on any ready cycle with a pending legal write
  assign w_wr  = r_pend && r_write && w_rdy;
  assign w_fwd = w_wr && (r_idx == w_idx);
  assign HREADYOUT = w_rdy;
  assign HRDATA    = r_rdata;
  always_comb begin
    w_be    = '0;
    w_rword = '0;
    for (int b = 0; b < NB; b++) begin
      w_be[b] = (((AW)'(b) ^ HADDR[AW-1:0]) >> HSIZE) == '0;
      w_rword[8*b +: 8] = (w_fwd && r_be[b]) ? HWDATA[8*b +: 8] : r_mem[w_idx][8*b +: 8];
    end
  end
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    HRESP       = (r_state == ERR1 || r_state == ERR2) ? 2'b01 : 2'b00;
    case (r_state)
      WAIT: begin
        w_cnt_nxt   = r_cnt - 4'd1;
        w_state_nxt = (r_cnt == 4'd1) ? IDLE : WAIT;
      end
      ERR1: w_state_nxt = ERR2;
      default: begin
        w_state_nxt = !w_acc ? IDLE : w_ill ? ERR1 : (WAIT_STATES == 0) ? IDLE : WAIT;
        w_cnt_nxt   = (w_ok && WAIT_STATES != 0) ? 4'(WAIT_STATES) : 4'd0;
      end
    endcase
  end
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_pend  <= 1'b0;
      r_write <= 1'b0;
      r_idx   <= '0;
      r_be    <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pend  <= w_ok || (r_pend && !w_rdy);
      if (w_ok) begin
        r_write <= HWRITE;
        r_idx   <= w_idx;
        r_be    <= w_be;
      end
      if (w_ok && !HWRITE) r_rdata <= w_rword;
    end
  end
  always_ff @(posedge HCLK) begin
    for (int b = 0; b < NB; b++)
      if (w_wr && r_be[b]) r_mem[r_idx][8*b +: 8] <= HWDATA[8*b +: 8];
  end
endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// tb_ahb_lite_sram_slave: directed checks of three slaves with 0, 3 and 4 wait states sharing one bus.
module tb_ahb_lite_sram_slave;
  logic        clk;
  logic        r0, r3, r4, s0, s3, s4;
  logic [31:0] HADDR, HWDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic        ro0, ro3, ro4;
  logic [1:0]  rp0, rp3, rp4;
  logic [31:0] rd0, rd3, rd4;
  int          checks, errors, n;
  ahb_lite_sram_slave #(.DATA_WIDTH(32), .DEPTH_WORDS(256), .WAIT_STATES(0)) u0 (
    .HCLK(clk), .HRESET(r0), .HSEL(s0), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(ro0), .HREADYOUT(ro0), .HRESP(rp0), .HRDATA(rd0));
  ahb_lite_sram_slave #(.DATA_WIDTH(32), .DEPTH_WORDS(256), .WAIT_STATES(3)) u3 (
    .HCLK(clk), .HRESET(r3), .HSEL(s3), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(ro3), .HREADYOUT(ro3), .HRESP(rp3), .HRDATA(rd3));
  ahb_lite_sram_slave #(.DATA_WIDTH(32), .DEPTH_WORDS(256), .WAIT_STATES(4)) u4 (
    .HCLK(clk), .HRESET(r4), .HSEL(s4), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(ro4), .HREADYOUT(ro4), .HRESP(rp4), .HRDATA(rd4));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic ap(input logic [1:0] t, input logic w, input logic [2:0] s, input logic [31:0] a);
    HTRANS = t;
    HWRITE = w;
    HSIZE  = s;
    HADDR  = a;
  endtask
  task automatic step();
    @(negedge clk);
  endtask
  task automatic waitrdy(input int which, output int cnt);
    cnt = 0;
    while (((which == 3) ? ro3 : ro4) !== 1'b1 && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
  endtask
  initial begin
    checks = 0; errors = 0;
    r0 = 1; r3 = 1; r4 = 1; s0 = 0; s3 = 0; s4 = 0;
    HWDATA = 0; ap(2'b00, 0, 3'd2, 32'h0);
    step();
    chk("rst_ready", {31'd0, ro0}, 32'd1);
    chk("rst_resp", {30'd0, rp0}, 32'd0);
    chk("rst_rdata", rd0, 32'h0);
    step();
    r0 = 0; r3 = 0; r4 = 0; s0 = 1;
    ap(2'b10, 1, 3'd2, 32'h10); step();
    HWDATA = 32'hDEADBEEF; ap(2'b10, 0, 3'd2, 32'h10);
    chk("b2b_wr_ready", {31'd0, ro0}, 32'd1);
    chk("b2b_wr_resp", {30'd0, rp0}, 32'd0);
    step();
    ap(2'b00, 0, 3'd2, 32'h0);
    chk("b2b_rd_ready", {31'd0, ro0}, 32'd1);
    chk("b2b_rd_resp", {30'd0, rp0}, 32'd0);
    chk("b2b_rd_data", rd0, 32'hDEADBEEF);
    step();
    ap(2'b10, 1, 3'd2, 32'h10); step();
    HWDATA = 32'h11223344; ap(2'b10, 1, 3'd0, 32'h13); step();
    HWDATA = 32'hAA000000; ap(2'b10, 0, 3'd2, 32'h10); step();
    ap(2'b00, 0, 3'd2, 32'h0);
    chk("byte_lane_fwd", rd0, 32'hAA223344);
    step();
    chk("rdata_hold_idle", rd0, 32'hAA223344);
    ap(2'b10, 1, 3'd2, 32'h14); step();
    HWDATA = 32'h0; ap(2'b10, 1, 3'd1, 32'h16); step();
    HWDATA = 32'hCAFE0000; ap(2'b00, 0, 3'd2, 32'h0);
    chk("rdata_hold_write", rd0, 32'hAA223344);
    step();
    ap(2'b10, 0, 3'd2, 32'h14); step();
    ap(2'b00, 0, 3'd2, 32'h0);
    chk("half_lane", rd0, 32'hCAFE0000);
    step();
    ap(2'b10, 0, 3'd2, 32'h10); step();
    ap(2'b00, 0, 3'd2, 32'h0);
    chk("mem_read", rd0, 32'hAA223344);
    step();
    ap(2'b10, 1, 3'd2, 32'h0); step();
    HWDATA = 32'h0; ap(2'b10, 1, 3'd2, 32'h400); step();
    chk("oob_err1_ready", {31'd0, ro0}, 32'd0);
    chk("oob_err1_resp", {30'd0, rp0}, 32'd1);
    HWDATA = 32'hFFFFFFFF; ap(2'b00, 0, 3'd2, 32'h0); step();
    chk("oob_err2_ready", {31'd0, ro0}, 32'd1);
    chk("oob_err2_resp", {30'd0, rp0}, 32'd1);
    step();
    chk("oob_idle_resp", {30'd0, rp0}, 32'd0);
    ap(2'b10, 1, 3'd1, 32'h01); step();
    chk("misalign_err1_ready", {31'd0, ro0}, 32'd0);
    chk("misalign_err1_resp", {30'd0, rp0}, 32'd1);
    HWDATA = 32'hFFFFFFFF; ap(2'b00, 0, 3'd2, 32'h0); step();
    chk("misalign_err2_ready", {31'd0, ro0}, 32'd1);
    chk("misalign_err2_resp", {30'd0, rp0}, 32'd1);
    step();
    ap(2'b10, 1, 3'd3, 32'h08); step();
    chk("size_err1_resp", {30'd0, rp0}, 32'd1);
    ap(2'b00, 0, 3'd2, 32'h0); step(); step();
    ap(2'b10, 0, 3'd2, 32'h0); step();
    ap(2'b00, 0, 3'd2, 32'h0);
    chk("err_mem_unchanged", rd0, 32'h0);
    step();
    ap(2'b01, 1, 3'd2, 32'h0); step();
    chk("busy_ready", {31'd0, ro0}, 32'd1);
    chk("busy_resp", {30'd0, rp0}, 32'd0);
    HWDATA = 32'hFFFFFFFF; s0 = 0; ap(2'b10, 1, 3'd2, 32'h0); step();
    chk("nosel_ready", {31'd0, ro0}, 32'd1);
    chk("nosel_resp", {30'd0, rp0}, 32'd0);
    s0 = 1; ap(2'b00, 0, 3'd2, 32'h0); step();
    ap(2'b10, 0, 3'd2, 32'h0); step();
    ap(2'b00, 0, 3'd2, 32'h0);
    chk("no_access_mem", rd0, 32'h0);
    step();
    s0 = 0; s3 = 1;
    ap(2'b10, 1, 3'd2, 32'h08); step();
    HWDATA = 32'h0BADF00D; ap(2'b00, 0, 3'd2, 32'h0);
    waitrdy(3, n);
    chk("ws3_wr_stall", n, 32'd3);
    ap(2'b10, 0, 3'd2, 32'h08); step();
    ap(2'b00, 0, 3'd2, 32'h0);
    waitrdy(3, n);
    chk("ws3_rd_stall", n, 32'd3);
    chk("ws3_rd_ready", {31'd0, ro3}, 32'd1);
    chk("ws3_rd_resp", {30'd0, rp3}, 32'd0);
    chk("ws3_rd_data", rd3, 32'h0BADF00D);
    step();
    s3 = 0; s4 = 1;
    ap(2'b10, 1, 3'd2, 32'h20); step();
    HWDATA = 32'h11111111; ap(2'b00, 0, 3'd2, 32'h0);
    waitrdy(4, n);
    chk("ws4_wr_stall", n, 32'd4);
    ap(2'b10, 1, 3'd0, 32'h20); step();
    HWDATA = 32'h00000055; ap(2'b00, 0, 3'd2, 32'h0);
    chk("ws4_wait1", {31'd0, ro4}, 32'd0);
    step();
    chk("ws4_wait2", {31'd0, ro4}, 32'd0);
    r4 = 1; #1;
    chk("ws4_rst_ready", {31'd0, ro4}, 32'd1);
    chk("ws4_rst_resp", {30'd0, rp4}, 32'd0);
    chk("ws4_rst_rdata", rd4, 32'h0);
    step();
    r4 = 0; step();
    ap(2'b10, 0, 3'd2, 32'h20); step();
    ap(2'b00, 0, 3'd2, 32'h0);
    waitrdy(4, n);
    chk("ws4_rd_stall", n, 32'd4);
    chk("ws4_abort_nowrite", rd4, 32'h11111111);
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
